// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a FIFO absorbs decoder bursts and an FSM
// serialises queued bytes onto q, running frames back-to-back while data waits.
module uart_tx_buffered #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   q,
    output logic                   active,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t              state;
    logic [TMR_W-1:0]    timer;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_next;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   head;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push;

    assign empty      = (fifo_count == '0);
    assign full       = (fifo_count == CNT_FULL);
    assign head       = mem[rd_ptr];
    assign shift_next = shift_reg >> 1;

    // The FSM takes the head either from idle or on the final stop cycle.
    assign pop  = !empty && ((state == StIdle) || ((state == StStop) && (timer == '0)));
    // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
    assign push = in_valid && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            q         <= 1'b1;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    q      <= 1'b1;
                    active <= 1'b0;
                    if (pop) begin
                        shift_reg <= head;
                        timer     <= TMR_LAST;
                        state     <= StStart;
                        q         <= 1'b0;
                        active    <= 1'b1;
                    end
                end
                StStart: begin
                    if (timer == '0) begin
                        timer   <= TMR_LAST;
                        bit_idx <= '0;
                        state   <= StData;
                        q       <= shift_reg[0];
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                StData: begin
                    if (timer == '0) begin
                        timer <= TMR_LAST;
                        if (bit_idx == IDX_LAST) begin
                            state <= StStop;
                            q     <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            shift_reg <= shift_next;
                            q         <= shift_next[0];
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                StStop: begin
                    if (timer == '0) begin
                        if (pop) begin
                            shift_reg <= head;
                            timer     <= TMR_LAST;
                            state     <= StStart;
                            q         <= 1'b0;
                        end else begin
                            state  <= StIdle;
                            q      <= 1'b1;
                            active <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                        // Registered, so raise it one edge early to land on the last stop cycle.
                        done  <= (timer == TMR_W'(1));
                    end
                end
                default: begin
                    state  <= StIdle;
                    q      <= 1'b1;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
